// File: rtl/vpu_ram_arbiter.sv
// rtl/vpu_ram_arbiter.sv - two-master single-port RAM arbiter with a fill engine.
// Define VPU_ARB_RR_EN for round-robin arbitration; fixed priority (m0 first) otherwise.
module vpu_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic              fill_start,
    input  logic [ADDR_W-1:0] fill_base,
    input  logic [ADDR_W:0]   fill_len,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic {IDLE, FILL} state_t;

    localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LEN_ZERO = '0;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   len_r;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   count_inc;
    logic [DATA_W-1:0] value_r;
    logic              g0, g1;
    logic              fill_last;
    logic              fill_accept;

    assign count_inc   = count + LEN_ONE;
    assign fill_last   = (state == FILL) && (count_inc == len_r);
    assign fill_accept = (state == IDLE) && fill_start;

`ifdef VPU_ARB_RR_EN
    // rr_ptr=1 means m0 was granted last, so m1 wins the next contended cycle
    logic rr_ptr;

    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (state == IDLE) begin
            if (m0_req && m1_req) begin
                g0 = ~rr_ptr;
                g1 = rr_ptr;
            end else begin
                g0 = m0_req;
                g1 = m1_req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rr_ptr <= 1'b0;
        else if (g0) rr_ptr <= 1'b1;
        else if (g1) rr_ptr <= 1'b0;
    end
`else
    always_comb begin
        g0 = (state == IDLE) && m0_req;
        g1 = (state == IDLE) && m1_req && !m0_req;
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (fill_start && fill_len != LEN_ZERO) state_nxt = FILL;
            FILL: if (fill_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are gated by rst_n so nothing leaks onto the RAM port during reset
    always_comb begin
        m0_gnt   = 1'b0;
        m1_gnt   = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (rst_n) begin
            m0_gnt = g0;
            m1_gnt = g1;
            if (state == FILL) begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = base_r + count[ADDR_W-1:0];
                ram_din  = value_r;
            end else if (g0) begin
                ram_en   = 1'b1;
                ram_we   = m0_we;
                ram_addr = m0_addr;
                ram_din  = m0_wdata;
            end else if (g1) begin
                ram_en   = 1'b1;
                ram_we   = m1_we;
                ram_addr = m1_addr;
                ram_din  = m1_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base_r    <= '0;
            len_r     <= '0;
            value_r   <= '0;
            count     <= '0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            m0_rvalid <= g0 && !m0_we;
            m1_rvalid <= g1 && !m1_we;
            fill_done <= fill_last || (fill_accept && fill_len == LEN_ZERO);
            if (fill_accept) begin
                base_r  <= fill_base;
                len_r   <= fill_len;
                value_r <= fill_value;
                count   <= '0;
            end else if (state == FILL) begin
                count <= fill_last ? LEN_ZERO : count_inc;
            end
        end
    end

    assign fill_busy = (state == FILL);
    assign m0_rdata  = ram_dout;
    assign m1_rdata  = ram_dout;

endmodule

// File: tb/tb_vpu_ram_arbiter.sv
// tb/tb_vpu_ram_arbiter.sv - scoreboard bench for vpu_ram_arbiter with a behavioural RAM.
module tb_vpu_ram_arbiter;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [7:0] m0_addr, m0_wdata, m0_rdata;
    logic       m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [7:0] m1_addr, m1_wdata, m1_rdata;
    logic       fill_start, fill_busy, fill_done;
    logic [7:0] fill_base, fill_value;
    logic [8:0] fill_len;
    logic       ram_en, ram_we;
    logic [7:0] ram_addr, ram_din, ram_dout;

    logic [7:0] mem [256];
    wr_t        wq[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    wr_t        mon_e;
    logic [7:0] mon_d;
    int         vectors = 0;
    int         miscompares = 0;

    vpu_ram_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        ram_dout = 8'h00;
    end

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every RAM write and every rvalid is matched against the scoreboard queues
    always @(negedge clk) begin
        if (ram_en && ram_we) begin
            vectors++;
            if (wq.size() == 0) begin
                miscompares++;
                $display("FAIL write_unexpected: got addr %0h data %0h, expected no write", ram_addr, ram_din);
            end else begin
                mon_e = wq.pop_front();
                if (ram_addr !== mon_e.a || ram_din !== mon_e.d) begin
                    miscompares++;
                    $display("FAIL ram_write: got addr %0h data %0h, expected addr %0h data %0h",
                             ram_addr, ram_din, mon_e.a, mon_e.d);
                end
            end
        end
        if (m0_rvalid) begin
            vectors++;
            if (q0.size() == 0) begin
                miscompares++;
                $display("FAIL m0_rvalid_unexpected: got rdata %0h, expected no rvalid", m0_rdata);
            end else begin
                mon_d = q0.pop_front();
                if (m0_rdata !== mon_d) begin
                    miscompares++;
                    $display("FAIL m0_rdata: got %0h, expected %0h", m0_rdata, mon_d);
                end
            end
        end
        if (m1_rvalid) begin
            vectors++;
            if (q1.size() == 0) begin
                miscompares++;
                $display("FAIL m1_rvalid_unexpected: got rdata %0h, expected no rvalid", m1_rdata);
            end else begin
                mon_d = q1.pop_front();
                if (m1_rdata !== mon_d) begin
                    miscompares++;
                    $display("FAIL m1_rdata: got %0h, expected %0h", m1_rdata, mon_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        fill_start = 0; fill_base = 0; fill_len = 0; fill_value = 0;
    endtask

    task automatic m0_set(input logic we, input logic [7:0] a, input logic [7:0] d);
        m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d;
    endtask

    task automatic m1_set(input logic we, input logic [7:0] a, input logic [7:0] d);
        m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d;
    endtask

    task automatic start_fill(input logic [7:0] b, input logic [8:0] l, input logic [7:0] v);
        fill_start = 1; fill_base = b; fill_len = l; fill_value = v;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},    {30'd0, m0_gnt, m1_gnt}, 0);
        chk({tag, "_rvalid"}, {30'd0, m0_rvalid, m1_rvalid}, 0);
        chk({tag, "_fill"},   {30'd0, fill_busy, fill_done}, 0);
        chk({tag, "_ram_en_we"}, {30'd0, ram_en, ram_we}, 0);
        chk({tag, "_ram_addr_din"}, {16'd0, ram_addr, ram_din}, 0);
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        m0_set(1, 8'h33, 8'h44);
        m1_set(1, 8'h34, 8'h45);
        tick(); settle();
        chk_all_zero("reset");
        tick();
        rst_n = 1;
        idle_inputs();

        // Scenario 1: write then read back on m0
        tick(); m0_set(1, 8'h10, 8'hA5); wq.push_back('{8'h10, 8'hA5});
        settle(); chk("s1_wr_gnt", m0_gnt, 1);
        tick(); m0_set(0, 8'h10, 8'h00); q0.push_back(8'hA5);
        settle(); chk("s1_rd_gnt", m0_gnt, 1);
        tick(); idle_inputs();
        settle(); chk("s1_rvalid", m0_rvalid, 1);
        tick(); settle(); chk("s1_rvalid_once", m0_rvalid, 0);

        // Scenario 2: set up data, then contend for four cycles
        tick(); m0_set(1, 8'h20, 8'h11); wq.push_back('{8'h20, 8'h11});
        tick(); m0_req = 0; m1_set(1, 8'h21, 8'h22); wq.push_back('{8'h21, 8'h22});
        settle(); chk("s2_m1_wr_gnt", m1_gnt, 1);
        for (int i = 0; i < 4; i++) begin
            tick(); m0_set(0, 8'h20, 8'h00); m1_set(0, 8'h21, 8'h00);
            settle();
`ifdef VPU_ARB_RR_EN
            chk($sformatf("s2_gnt%0d", i), {30'd0, m0_gnt, m1_gnt}, (i % 2 == 0) ? 2 : 1);
            if (i % 2 == 0) q0.push_back(8'h11); else q1.push_back(8'h22);
`else
            chk($sformatf("s2_gnt%0d", i), {30'd0, m0_gnt, m1_gnt}, 2);
            q0.push_back(8'h11);
`endif
        end
        tick(); idle_inputs();
        tick();

        // Scenario 3: wrapping fill; a second fill_start mid-fill must be ignored
        tick(); start_fill(8'hFE, 9'd4, 8'h3C);
        wq.push_back('{8'hFE, 8'h3C}); wq.push_back('{8'hFF, 8'h3C});
        wq.push_back('{8'h00, 8'h3C}); wq.push_back('{8'h01, 8'h3C});
        settle(); chk("s3_busy_T", fill_busy, 0);
        for (int i = 1; i <= 4; i++) begin
            tick(); idle_inputs();
            if (i == 2) start_fill(8'h30, 9'd2, 8'h99);
            settle();
            chk($sformatf("s3_busy_T%0d", i), fill_busy, 1);
            chk($sformatf("s3_done_T%0d", i), fill_done, 0);
        end
        tick(); idle_inputs(); settle();
        chk("s3_done_T5", fill_done, 1);
        chk("s3_busy_T5", fill_busy, 0);
        tick(); settle(); chk("s3_done_pulse", fill_done, 0);

        // Scenario 4: zero-length fill
        tick(); start_fill(8'h50, 9'd0, 8'hAA);
        settle(); chk("s4_we_T", ram_we, 0);
        tick(); idle_inputs(); settle();
        chk("s4_done_T1", fill_done, 1);
        chk("s4_busy_T1", fill_busy, 0);
        chk("s4_we_T1", ram_we, 0);

        // Scenario 5: m1 held off by a len-3 fill, granted alongside fill_done
        tick(); idle_inputs(); start_fill(8'h40, 9'd3, 8'h77);
        wq.push_back('{8'h40, 8'h77}); wq.push_back('{8'h41, 8'h77}); wq.push_back('{8'h42, 8'h77});
        wq.push_back('{8'h50, 8'h99});
        for (int i = 1; i <= 3; i++) begin
            tick(); idle_inputs(); m1_set(1, 8'h50, 8'h99); settle();
            chk($sformatf("s5_m1_gnt_T%0d", i), m1_gnt, 0);
        end
        tick(); settle();
        chk("s5_m1_gnt_T4", m1_gnt, 1);
        chk("s5_done_T4", fill_done, 1);
        tick(); idle_inputs(); m0_set(0, 8'h41, 8'h00); q0.push_back(8'h77);
        tick(); idle_inputs();
        tick();

        // Scenario 6: reset after the second fill write aborts the fill
        tick(); start_fill(8'h80, 9'd5, 8'hEE);
        wq.push_back('{8'h80, 8'hEE}); wq.push_back('{8'h81, 8'hEE});
        tick(); idle_inputs();
        tick();
        tick(); rst_n = 0; m0_set(1, 8'h90, 8'h55); m1_set(1, 8'h91, 8'h66);
        settle(); chk_all_zero("s6_rst");
        tick(); settle(); chk("s6_rst_done", fill_done, 0);
        tick(); rst_n = 1; wq.push_back('{8'h90, 8'h55});
        settle();
        chk("s6_gnt_after_rst", {30'd0, m0_gnt, m1_gnt}, 2);
        chk("s6_busy_after_rst", fill_busy, 0);
        tick(); m0_req = 0; wq.push_back('{8'h91, 8'h66});
        settle();
        chk("s6_m1_gnt", m1_gnt, 1);
        chk("s6_no_done", fill_done, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); idle_inputs(); settle();
            chk($sformatf("s6_quiet%0d", i), {30'd0, fill_done, fill_busy}, 0);
        end

        chk("wq_drained", wq.size(), 0);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
